// File: rtl/pc_sequencer.sv
// Control sequencer between program memory and the program counter: decodes the
// current opcode into PC strobes, keeps the zero flag and handles WAIT/HALT.
module pc_sequencer #(
    parameter int P_SIZE = 6
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic [3:0]        opcode,
    input  logic [P_SIZE-1:0] imm,
    input  logic              aluZero,
    input  logic              button,
    output logic              inc,
    output logic              branchAbs,
    output logic              branchRel,
    output logic [P_SIZE-1:0] branchAddress,
    output logic              regWrite,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT_PRESS,
        S_WAIT_RELEASE,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ALU  = 4'd1;
    localparam logic [3:0] OP_JMP  = 4'd2;
    localparam logic [3:0] OP_BEQ  = 4'd3;
    localparam logic [3:0] OP_BNE  = 4'd4;
    localparam logic [3:0] OP_WAIT = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd6;

    state_t state_q, state_d;
    logic   zFlag_q, zFlag_d;
    logic   btnMeta_q, btnS_q;
    logic   incRaw, absRaw, relRaw, wrRaw;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= S_RUN;
            zFlag_q   <= 1'b0;
            btnMeta_q <= 1'b0;
            btnS_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            zFlag_q   <= zFlag_d;
            btnMeta_q <= button;
            btnS_q    <= btnMeta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        zFlag_d = zFlag_q;
        incRaw  = 1'b0;
        absRaw  = 1'b0;
        relRaw  = 1'b0;
        wrRaw   = 1'b0;
        unique case (state_q)
            S_RUN: begin
                case (opcode)
                    OP_ALU: begin
                        incRaw  = 1'b1;
                        wrRaw   = 1'b1;
                        zFlag_d = aluZero;
                    end
                    OP_JMP:  absRaw = 1'b1;
                    OP_BEQ: begin
                        relRaw = zFlag_q;
                        incRaw = ~zFlag_q;
                    end
                    OP_BNE: begin
                        relRaw = ~zFlag_q;
                        incRaw = zFlag_q;
                    end
                    OP_WAIT: state_d = S_WAIT_PRESS;
                    OP_HALT: state_d = S_HALT;
                    default: incRaw = 1'b1;
                endcase
            end
            S_WAIT_PRESS: begin
                if (btnS_q) state_d = S_WAIT_RELEASE;
            end
            // Stepping the PC on release moves it past the WAIT instruction.
            S_WAIT_RELEASE: begin
                if (!btnS_q) begin
                    incRaw  = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    // Strobes are held off combinationally for as long as reset is asserted.
    assign inc           = incRaw & nRst;
    assign branchAbs     = absRaw & nRst;
    assign branchRel     = relRaw & nRst;
    assign regWrite      = wrRaw & nRst;
    assign halted        = (state_q == S_HALT);
    assign branchAddress = imm;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed vector table, hand-written multi-cycle
// sequences and a randomized run checked against a behavioural model.
module tb_pc_sequencer;

    localparam int P = 6;

    logic         clk = 1'b0;
    logic         nRst = 1'b0;
    logic [3:0]   opcode = 4'd0;
    logic [P-1:0] imm = '0;
    logic         aluZero = 1'b0;
    logic         button = 1'b0;
    logic         inc, branchAbs, branchRel, regWrite, halted;
    logic [P-1:0] branchAddress;

    int vectors = 0;
    int miscompares = 0;
    logic [P-1:0] tbPc = '0;

    // Model: mode 0 running, 1 waiting for press, 2 waiting for release, 3 halted.
    int   mMode = 0;
    bit   mZ = 0;
    bit   mBtn1 = 0;
    bit   mBtn2 = 0;

    typedef struct {
        logic [3:0]   op;
        logic [P-1:0] im;
        logic         az;
        logic [4:0]   exp;
    } vec_t;

    pc_sequencer #(.P_SIZE(P)) dut (
        .clk(clk), .nRst(nRst), .opcode(opcode), .imm(imm), .aluZero(aluZero),
        .button(button), .inc(inc), .branchAbs(branchAbs), .branchRel(branchRel),
        .branchAddress(branchAddress), .regWrite(regWrite), .halted(halted)
    );

    always #5 clk = ~clk;

    // Expected outputs packed as {inc, branchAbs, branchRel, regWrite, halted}.
    function automatic logic [4:0] modelOut(input logic [3:0] op);
        logic [4:0] e;
        e = 5'b00000;
        if (mMode == 3) e = 5'b00001;
        else if (mMode == 2 && !mBtn2) e = 5'b10000;
        else if (mMode == 0) begin
            if (op == 4'd1) e = 5'b10010;
            else if (op == 4'd2) e = 5'b01000;
            else if (op == 4'd3) e = mZ ? 5'b00100 : 5'b10000;
            else if (op == 4'd4) e = mZ ? 5'b10000 : 5'b00100;
            else if (op == 4'd5 || op == 4'd6) e = 5'b00000;
            else e = 5'b10000;
        end
        return e;
    endfunction

    task automatic modelAdvance(input logic [3:0] op, input logic az, input logic bt);
        if (mMode == 0) begin
            if (op == 4'd1) mZ = az;
            if (op == 4'd5) mMode = 1;
            if (op == 4'd6) mMode = 3;
        end else if (mMode == 1) begin
            if (mBtn2) mMode = 2;
        end else if (mMode == 2) begin
            if (!mBtn2) mMode = 0;
        end
        mBtn2 = mBtn1;
        mBtn1 = bt;
    endtask

    task automatic modelReset();
        mMode = 0; mZ = 0; mBtn1 = 0; mBtn2 = 0;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [P-1:0] im,
                                 input logic az, input logic bt);
        opcode = op; imm = im; aluZero = az; button = bt;
    endtask

    task automatic checkOutput(input string name, input logic [4:0] exp, input logic [P-1:0] im);
        logic [4:0] got;
        got = {inc, branchAbs, branchRel, regWrite, halted};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: {inc,abs,rel,wr,halted} got %b expected %b", name, got, exp);
        end
        vectors++;
        if (branchAddress !== im) begin
            miscompares++;
            $display("[TB] FAIL %s branchAddress: got %0d expected %0d", name, branchAddress, im);
        end
        vectors++;
        if ((32'(inc) + 32'(branchAbs) + 32'(branchRel)) > 1) begin
            miscompares++;
            $display("[TB] FAIL %s onehot: got %b%b%b expected at most one high",
                     name, inc, branchAbs, branchRel);
        end
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic runVector(input logic [3:0] op, input logic [P-1:0] im, input logic az,
                             input logic bt, input logic [4:0] exp, input string name);
        applyStimulus(op, im, az, bt);
        @(negedge clk);
        checkOutput(name, exp, im);
        if (inc) tbPc = tbPc + 1'b1;
        else if (branchAbs) tbPc = imm;
        else if (branchRel) tbPc = tbPc + imm;
        @(posedge clk);
        #1;
    endtask

    task automatic modelStep(input logic [3:0] op, input logic [P-1:0] im, input logic az,
                             input logic bt, input string name);
        runVector(op, im, az, bt, modelOut(op), name);
        modelAdvance(op, az, bt);
    endtask

    task automatic resetDut();
        nRst = 1'b0;
        applyStimulus(4'd2, 6'd17, 1'b1, 1'b0);
        #3;
        checkOutput("reset", 5'b00000, 6'd17);
        @(negedge clk);
        nRst = 1'b1;
        opcode = 4'd0;
        @(posedge clk);
        #1;
        tbPc = '0;
        modelReset();
    endtask

    task automatic checkPc(input string name, input logic [P-1:0] exp);
        vectors++;
        if (tbPc !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: pc got %0d expected %0d", name, tbPc, exp);
        end
    endtask

    initial begin
        vec_t tbl[15];
        int   incCount;
        bit   released;
        logic bt;
        logic [3:0] op;

        tbl[0]  = '{4'd0,  6'd0,  1'b0, 5'b10000};
        tbl[1]  = '{4'd2,  6'd5,  1'b0, 5'b01000};
        tbl[2]  = '{4'd4,  6'd8,  1'b0, 5'b00100};
        tbl[3]  = '{4'd3,  6'd3,  1'b0, 5'b10000};
        tbl[4]  = '{4'd1,  6'd0,  1'b1, 5'b10010};
        tbl[5]  = '{4'd3,  6'd3,  1'b0, 5'b00100};
        tbl[6]  = '{4'd4,  6'd7,  1'b0, 5'b10000};
        tbl[7]  = '{4'd1,  6'd0,  1'b0, 5'b10010};
        tbl[8]  = '{4'd3,  6'd3,  1'b1, 5'b10000};
        tbl[9]  = '{4'd4,  6'd62, 1'b1, 5'b00100};
        tbl[10] = '{4'd7,  6'd1,  1'b0, 5'b10000};
        tbl[11] = '{4'd15, 6'd2,  1'b1, 5'b10000};
        tbl[12] = '{4'd9,  6'd3,  1'b0, 5'b10000};
        tbl[13] = '{4'd2,  6'd40, 1'b1, 5'b01000};
        tbl[14] = '{4'd4,  6'd9,  1'b1, 5'b00100};

        #2;
        resetDut();
        for (int i = 0; i < 15; i++)
            runVector(tbl[i].op, tbl[i].im, tbl[i].az, 1'b0, tbl[i].exp, $sformatf("table%0d", i));

        // JMP then BNE moves the PC 0 -> 5 -> 13.
        resetDut();
        modelStep(4'd2, 6'd5, 1'b0, 1'b0, "jmp5");
        checkPc("pcAfterJmp", 6'd5);
        modelStep(4'd4, 6'd8, 1'b0, 1'b0, "bne8");
        checkPc("pcAfterBne", 6'd13);

        // 64 NOPs run the PC all the way round.
        resetDut();
        for (int i = 0; i < 64; i++) begin
            modelStep(4'd0, 6'($urandom_range(0, 63)), 1'b0, 1'b0, "nopRun");
            if (i == 62) checkPc("pcAt63", 6'd63);
        end
        checkPc("pcWrap", 6'd0);

        // WAIT at PC 10: button low 5, high 4, then low until release.
        resetDut();
        modelStep(4'd2, 6'd10, 1'b0, 1'b0, "jmp10");
        incCount = 0;
        for (int i = 0; i < 9; i++) begin
            bt = (i >= 5);
            modelStep(4'd5, 6'd0, 1'b0, bt, "waitHold");
            checkPc("waitPcHold", 6'd10);
        end
        released = 0;
        for (int i = 0; i < 8; i++) begin
            op = released ? 4'd0 : 4'd5;
            modelStep(op, 6'd0, 1'b0, 1'b0, "waitTail");
            if (!released && tbPc != 6'd10) begin
                released = 1;
                incCount++;
                checkPc("waitPcStep", 6'd11);
            end
        end
        vectors++;
        if (incCount != 1) begin
            miscompares++;
            $display("[TB] FAIL waitIncPulses: got %0d expected 1", incCount);
        end

        // Halt absorbs opcodes; async reset releases it and clears zFlag.
        resetDut();
        modelStep(4'd1, 6'd0, 1'b1, 1'b0, "aluZ1");
        modelStep(4'd6, 6'd0, 1'b0, 1'b0, "halt");
        for (int i = 0; i < 20; i++)
            modelStep(4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 1'b1, 1'b0, "halted");
        #2;
        nRst = 1'b0;
        #1;
        checkOutput("asyncReset", 5'b00000, imm);
        @(negedge clk);
        nRst = 1'b1;
        opcode = 4'd0;
        @(posedge clk);
        #1;
        modelReset();
        modelStep(4'd3, 6'd3, 1'b0, 1'b0, "beqAfterReset");

        // Randomized run against the model, with periodic resets to leave HALT.
        resetDut();
        bt = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (i % 80 == 79) begin
                resetDut();
                bt = 1'b0;
            end
            if ($urandom_range(0, 99) < 2) op = 4'd6;
            else begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'd6) op = 4'd1;
            end
            if ($urandom_range(0, 3) == 0) bt = ~bt;
            modelStep(op, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), bt, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Single-cycle control sequencer that drives the program counter's `inc`, `branchAbs`, `branchRel` and `branchAddress` inputs from the decoded instruction word. It also holds the zero flag and implements conditional branches, a wait-for-button handshake and a halt. It sits between program memory and the program counter, consuming the opcode and immediate of the instruction currently addressed.

## Interface
- `P_SIZE`, 6, program address width; also the width of `imm` and `branchAddress`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `nRst`  in  1  asynchronous, active-low reset.
- `opcode`  in  4  opcode of the current instruction.
- `imm`  in  P_SIZE  immediate field: absolute target, or two's-complement relative offset.
- `aluZero`  in  1  ALU result-is-zero flag for the current instruction.
- `button`  in  1  asynchronous user button, active high.
- `inc`  out  1  PC increment strobe.
- `branchAbs`  out  1  PC load-absolute strobe.
- `branchRel`  out  1  PC add-offset strobe.
- `branchAddress`  out  P_SIZE  target or offset; always equals `imm`.
- `regWrite`  out  1  register-file write enable.
- `halted`  out  1  high while in state HALT.

## Operation
- Opcodes:
  - 0 NOP
  - 1 ALU
  - 2 JMP
  - 3 BEQ
  - 4 BNE
  - 5 WAIT
  - 6 HALT
  - 7–15 treated as NOP.
- States: RUN, WAIT_PRESS, WAIT_RELEASE, HALT.
- Outputs are combinational from state, `opcode`, `zFlag` and the synchronised button (`btnS`). At most one of `inc`, `branchAbs` or `branchRel` is high in any cycle.
- In RUN:
  - NOP: `inc`=1.
  - ALU: `inc`=1, `regWrite`=1; `zFlag` <= `aluZero` at the clock edge.
  - JMP: `branchAbs`=1.
  - BEQ: `branchRel`=1 if `zFlag`=1, else `inc`=1.
  - BNE: `branchRel`=1 if `zFlag`=0, else `inc`=1.
  - WAIT: all strobes 0; next state WAIT_PRESS.
  - HALT: all strobes 0; next state HALT.
- WAIT_PRESS:
  - Strobes 0.
  - `btnS`=1 -> WAIT_RELEASE.
- WAIT_RELEASE:
  - Strobes 0 while `btnS`=1.
  - `btnS`=0 -> RUN with `inc`=1 in that same cycle, so the PC steps past the WAIT.
- HALT: absorbing; all strobes 0 and `regWrite`=0. Only reset leaves it.
- `zFlag` is written only by ALU instructions; branches and WAIT preserve it.
- `branchAddress` = `imm` unconditionally. Offset arithmetic, modulo 2^P_SIZE, is performed by the PC.
- Button synchroniser: two flops, reset to 0. `btnS` is the second flop.

## Timing
- Reset (`nRst`=0, asynchronous):
  - state=RUN, `zFlag`=0, synchroniser=0, `halted`=0.
  - All strobes and `regWrite` are forced to 0 while `nRst`=0, regardless of `opcode`.
- Decode latency is 0 cycles. The PC acts on the edge that ends the cycle in which the instruction is presented.
- ALU-to-branch: a BEQ/BNE immediately after an ALU sees that ALU's `aluZero`, since `zFlag` updates on the ALU's closing edge.
- Button latency: a `button` edge becomes visible in `btnS` after 2 rising edges. The state transition follows on the next edge.
- WAIT costs a minimum of 1 (RUN) + 1 (WAIT_PRESS) + 1 (WAIT_RELEASE) cycles, plus the synchroniser delay.
- Button already held when WAIT is decoded: go to WAIT_PRESS, then WAIT_RELEASE on the next edge; no extra press is required.
- Reset mid-WAIT or in HALT: return to RUN immediately; `zFlag` is cleared.
- Opcode changing while in WAIT_* or HALT: ignored.

## Test plan
- Reset, then `opcode`=0 for 64 cycles with a real programCounter (P_SIZE=6) -> `inc`=1 every cycle; PC runs 0..63 and wraps to 0.
- JMP with `imm`=5 -> `branchAbs`=1 for one cycle, `inc`=0; PC=5. Then BNE with `imm`=8 and `zFlag`=0 -> `branchRel`=1; PC=13.
- ALU with `aluZero`=1, then BEQ with `imm`=3 -> `regWrite`=1 in the ALU cycle and `branchRel`=1 in the BEQ cycle. Then ALU with `aluZero`=0, then BEQ -> `inc`=1 and `branchRel`=0.
- WAIT at PC=10, `button` low for 5 cycles, high for 4, then low -> PC holds 10 throughout. Exactly one `inc` pulse in the cycle `btnS` falls; PC=11. No strobes during the wait.
- HALT -> `halted`=1 and strobes 0 for 20 cycles despite `opcode` toggling. Assert `nRst`=0 mid-cycle -> `halted`=0 immediately (asynchronous) and `zFlag`=0.
- Opcodes 7–15 -> `inc`=1 only. Assert each cycle that no two of `inc`/`branchAbs`/`branchRel` are high together.
